uart_rx_fifo: RTL and testbench
===============================

Name: uart_rx_fifo

Overview:
Receive-side byte buffer sitting directly downstream of the UART receiver. It accepts one byte per single-cycle rx_valid strobe, stores up to DEPTH bytes, and presents them to the host or bus side over a first-word-fall-through valid/ready interface. It reports fill level and flags overflow when a byte arrives while the buffer is full.

Parameters:
DATA_W, 8, byte width; must match the receiver output.
DEPTH, 16, number of entries; power of two, minimum 2.
AFULL_LVL, 12, count at or above which afull asserts.

Ports:
clk  input  1  system clock, rising edge
arst  input  1  asynchronous active-high reset
en  input  1  block enable; low = synchronous flush
rx_data  input  DATA_W  byte from receiver
rx_valid  input  1  single-cycle strobe; rx_data valid this cycle
dout  output  DATA_W  head-of-queue byte
dout_valid  output  1  dout holds a valid byte
dout_ready  input  1  consumer takes dout when dout_valid && dout_ready
count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
empty  output  1  count == 0
full  output  1  count == DEPTH
afull  output  1  count >= AFULL_LVL
overflow  output  1  sticky: byte dropped while full
ovf_clr  input  1  clears overflow

Behaviour:
- Reset (arst high, asynchronous): wr_ptr=0, rd_ptr=0, count=0, dout=0, dout_valid=0, empty=1, full=0, afull=0, overflow=0. Storage array is not reset.
- Pointers: $clog2(DEPTH) bits; wrap modulo DEPTH naturally. count is tracked separately and one bit wider.
- push = en && rx_valid && (!full || pop). pop = en && dout_valid && dout_ready.
- Write: on push, mem[wr_ptr] <= rx_data and wr_ptr increments.
- Read: dout/dout_valid are registered and form a FWFT head register. A byte written into an empty FIFO appears on dout with dout_valid=1 on the cycle after the write edge, giving 1-cycle latency. There is no same-cycle bypass.
- On pop, the next entry loads into dout the next cycle. If none remains, dout_valid drops to 0 and dout holds its last value.
- count: +1 on push only, -1 on pop only, unchanged on both or neither. empty, full and afull are registered and consistent with count every cycle.
- Full with a simultaneous push and pop: both are accepted, count stays at DEPTH, and overflow is not set.
- Full with push and no pop: the byte is dropped and overflow is set to 1 on the next edge. Pointers and count are unchanged.
- Empty with a pop attempt: impossible, because dout_valid=0.
- overflow: sticky until ovf_clr=1. If a set event and ovf_clr occur in the same cycle, set wins.
- en low: synchronous flush at the next edge. Pointers, count and dout_valid go to 0, and all pushes and pops are ignored. overflow is retained.
- rx_valid held high for N cycles pushes N bytes. The upstream stage is responsible for single-cycle strobes.

Optional Feature:
Macro: UART_RX_FIFO_DROPCNT_EN
- Defined:
  - Adds output drop_cnt (8 bits), which increments on every dropped byte and saturates at 255.
  - drop_cnt clears to 0 on ovf_clr (no increment that cycle) and on arst.
  - drop_cnt is not cleared by en low.
- Undefined: the port and counter are absent, and there is no other change in behaviour.

Decomposition:
- Shared package uart_pkg:
  - UART_DATA_W = 8.
  - Default FIFO depth constant.
  - Pointer-width helper function.
  - FIFO status bit indices (EMPTY, FULL, AFULL, OVF) for later CSR use.
- One sub-module, uart_fifo_mem: simple dual-port storage array with a synchronous write port and an asynchronous read port. uart_rx_fifo owns the pointers, count, flags and head register.

Test Plan:
- Reset then idle: arst pulse → count=0, empty=1, dout_valid=0, overflow=0. Push 0xA5 → dout=0xA5 and dout_valid=1 one cycle after the push edge, count=1.
- Order and wrap: push 0x00..0x0F (16 bytes), then pop all with dout_ready=1 → output 0x00..0x0F in order, full=1 after the 16th push, empty=1 at the end. Repeat with 0x10..0x1F → correct order across the pointer wrap.
- Overflow: fill to 16, push 0x77 with dout_ready=0 → overflow=1, count=16, 0x77 never appears on dout. Assert ovf_clr → overflow=0.
- Full with simultaneous push/pop: at count=16, push 0x55 while popping → count stays 16, overflow=0, 0x55 emerges as the 16th byte after the current head.
- Flush: with count=5, drive en=0 for one cycle → count=0, dout_valid=0, overflow unchanged. rx_valid during en=0 is ignored.
- afull and dropcnt: at 12 entries → afull=1, at 11 → afull=0. With UART_RX_FIFO_DROPCNT_EN, 300 drops → drop_cnt=255.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants, status bit positions and pointer-width helper.
package uart_pkg;

  localparam int unsigned UART_DATA_W     = 8;
  localparam int unsigned UART_FIFO_DEPTH = 16;

  // Bit positions of the FIFO flags within a future status CSR.
  typedef enum logic [1:0] {
    UART_STAT_EMPTY = 2'd0,
    UART_STAT_FULL  = 2'd1,
    UART_STAT_AFULL = 2'd2,
    UART_STAT_OVF   = 2'd3
  } uart_stat_idx_e;

  function automatic int unsigned uart_ptr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-to-FIFO strobe and FIFO-to-consumer FWFT valid/ready handshake.
interface uart_rx_fifo_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready;

  modport master (
    output rx_data, rx_valid, dout_ready,
    input  dout, dout_valid
  );

  modport slave (
    input  rx_data, rx_valid, dout_ready,
    output dout, dout_valid
  );
endinterface

// File: rtl/uart_fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read, no reset.
module uart_fifo_mem #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned PTR_W  = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [PTR_W-1:0]  waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [PTR_W-1:0]  raddr,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];
endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO with registered FWFT head and sticky overflow.
// Optional drop counter enabled by `define UART_RX_FIFO_DROPCNT_EN.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int unsigned DATA_W    = UART_DATA_W,
  parameter  int unsigned DEPTH     = UART_FIFO_DEPTH,
  parameter  int unsigned AFULL_LVL = 12,
  localparam int unsigned PTR_W     = uart_ptr_w(DEPTH),
  localparam int unsigned CNT_W     = PTR_W + 1
) (
  input  logic             clk,
  input  logic             arst,
  input  logic             en,
  input  logic             ovf_clr,
  uart_rx_fifo_if.slave    bus,
  output logic [CNT_W-1:0] count,
  output logic             empty,
  output logic             full,
  output logic             afull,
  output logic             overflow
`ifdef UART_RX_FIFO_DROPCNT_EN
  ,
  output logic [7:0]       drop_cnt
`endif
);
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] dout_q, dout_d, mem_rdata;
  logic              dout_valid_q, dout_valid_d;
  logic              empty_q, empty_d, full_q, full_d, afull_q, afull_d;
  logic              overflow_q, overflow_d;
  logic              push, pop, drop, head_from_rx;

  assign pop  = en && dout_valid_q && bus.dout_ready;
  assign push = en && bus.rx_valid && (!full_q || pop);
  assign drop = en && bus.rx_valid && full_q && !pop;

  // The memory slot at rd_ptr mirrors the head; when the incoming byte becomes
  // the new head it has not been written yet, so it is taken from rx_data.
  assign head_from_rx = push && ((count_q == '0) || ((count_q == CNT_W'(1)) && pop));

  uart_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (bus.rx_data),
    .raddr (rd_ptr_d),
    .rdata (mem_rdata)
  );

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    if (!en) begin
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
      dout_valid_d = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      if (push && !pop)      count_d = count_q + CNT_W'(1);
      else if (pop && !push) count_d = count_q - CNT_W'(1);
      dout_valid_d = (count_d != '0);
      if (count_d != '0) dout_d = head_from_rx ? bus.rx_data : mem_rdata;
    end

    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else              overflow_d = overflow_q;

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_W'(DEPTH));
    afull_d = (count_d >= CNT_W'(AFULL_LVL));
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      afull_q      <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      afull_q      <= afull_d;
      overflow_q   <= overflow_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.dout_valid = dout_valid_q;
  assign count          = count_q;
  assign empty          = empty_q;
  assign full           = full_q;
  assign afull          = afull_q;
  assign overflow       = overflow_q;

`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;

  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (ovf_clr)                        drop_cnt_d = '0;
    else if (drop && drop_cnt_q != '1)  drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) drop_cnt_q <= '0;
    else      drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (default 8x16, AFULL_LVL 12).
module tb_uart_rx_fifo;
  logic       clk = 1'b0;
  logic       arst;
  logic       en;
  logic       ovf_clr;
  logic [4:0] count;
  logic       empty, full, afull, overflow;
`ifdef UART_RX_FIFO_DROPCNT_EN
  logic [7:0] drop_cnt;
`endif
  int unsigned assertions = 0;
  int unsigned failures   = 0;

  uart_rx_fifo_if #(.DATA_W(8)) bus ();

  uart_rx_fifo #(
    .DATA_W    (8),
    .DEPTH     (16),
    .AFULL_LVL (12)
  ) dut (
    .clk      (clk),
    .arst     (arst),
    .en       (en),
    .ovf_clr  (ovf_clr),
    .bus      (bus),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .afull    (afull),
    .overflow (overflow)
`ifdef UART_RX_FIFO_DROPCNT_EN
    ,
    .drop_cnt (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    assertions++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0;
  endtask

  task automatic pop_exp(input string tag, input logic [7:0] exp);
    check_val({tag, "_valid"}, 32'(bus.dout_valid), 32'd1);
    check_val(tag, 32'(bus.dout), 32'(exp));
    bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.dout_ready = 1'b0;
  endtask

  initial begin
    arst = 1'b1; en = 1'b1; ovf_clr = 1'b0;
    bus.rx_data = 8'h00; bus.rx_valid = 1'b0; bus.dout_ready = 1'b0;
    repeat (2) @(negedge clk);
    check_val("rst_count", 32'(count), 32'd0);
    check_val("rst_empty", 32'(empty), 32'd1);
    check_val("rst_full", 32'(full), 32'd0);
    check_val("rst_afull", 32'(afull), 32'd0);
    check_val("rst_dvalid", 32'(bus.dout_valid), 32'd0);
    check_val("rst_dout", 32'(bus.dout), 32'd0);
    check_val("rst_ovf", 32'(overflow), 32'd0);
    arst = 1'b0;
    @(negedge clk);

    // Single byte: visible one cycle after the write edge.
    push(8'hA5);
    check_val("a5_dout", 32'(bus.dout), 32'hA5);
    check_val("a5_valid", 32'(bus.dout_valid), 32'd1);
    check_val("a5_count", 32'(count), 32'd1);
    check_val("a5_empty", 32'(empty), 32'd0);
    pop_exp("a5_pop", 8'hA5);
    check_val("a5_after_valid", 32'(bus.dout_valid), 32'd0);
    check_val("a5_after_hold", 32'(bus.dout), 32'hA5);
    check_val("a5_after_empty", 32'(empty), 32'd1);

    // Two full rounds, the pointers start at 1 so both cross the wrap.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 16; i++) begin
        push(8'(r * 16 + i));
        if (i == 10) check_val("afull_at11", 32'(afull), 32'd0);
        if (i == 11) check_val("afull_at12", 32'(afull), 32'd1);
        if (i == 14) check_val("full_at15", 32'(full), 32'd0);
      end
      check_val("fill_count", 32'(count), 32'd16);
      check_val("fill_full", 32'(full), 32'd1);
      for (int i = 0; i < 16; i++) begin
        pop_exp("order", 8'(r * 16 + i));
        if (i == 3) check_val("afull_pop12", 32'(afull), 32'd1);
        if (i == 4) check_val("afull_pop11", 32'(afull), 32'd0);
      end
      check_val("drain_empty", 32'(empty), 32'd1);
      check_val("drain_count", 32'(count), 32'd0);
    end

    // Overflow: byte dropped, state unchanged, clear works.
    for (int i = 0; i < 16; i++) push(8'(8'h20 + i));
    push(8'h77);
    check_val("ovf_set", 32'(overflow), 32'd1);
    check_val("ovf_count", 32'(count), 32'd16);
    check_val("ovf_head", 32'(bus.dout), 32'h20);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check_val("dropcnt_1", 32'(drop_cnt), 32'd1);
`endif
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("ovf_clr", 32'(overflow), 32'd0);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check_val("dropcnt_clr", 32'(drop_cnt), 32'd0);
`endif

    // Full with simultaneous push and pop.
    bus.rx_data = 8'h55; bus.rx_valid = 1'b1; bus.dout_ready = 1'b1;
    @(negedge clk);
    bus.rx_valid = 1'b0; bus.dout_ready = 1'b0;
    check_val("pp_count", 32'(count), 32'd16);
    check_val("pp_ovf", 32'(overflow), 32'd0);
    for (int i = 1; i < 16; i++) pop_exp("pp_order", 8'(8'h20 + i));
    pop_exp("pp_last", 8'h55);
    check_val("pp_empty", 32'(empty), 32'd1);

    // Flush at count 5 with a strobe during en low.
    for (int i = 0; i < 5; i++) push(8'(8'h30 + i));
    check_val("f5_count", 32'(count), 32'd5);
    en = 1'b0; bus.rx_data = 8'hEE; bus.rx_valid = 1'b1;
    @(negedge clk);
    en = 1'b1; bus.rx_valid = 1'b0;
    check_val("f5_flush_count", 32'(count), 32'd0);
    check_val("f5_flush_valid", 32'(bus.dout_valid), 32'd0);
    check_val("f5_flush_empty", 32'(empty), 32'd1);
    check_val("f5_flush_ovf", 32'(overflow), 32'd0);
    push(8'h3C);
    pop_exp("f5_restart", 8'h3C);

    // Set beats clear, many drops, then flush keeps overflow.
    for (int i = 0; i < 16; i++) push(8'(8'h40 + i));
    push(8'h99);
    ovf_clr = 1'b1; bus.rx_valid = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("ovf_set_wins", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check_val("dropcnt_clr_wins", 32'(drop_cnt), 32'd0);
`endif
    repeat (300) @(negedge clk);
    bus.rx_valid = 1'b0;
    check_val("drops_count", 32'(count), 32'd16);
    check_val("drops_head", 32'(bus.dout), 32'h40);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check_val("dropcnt_sat", 32'(drop_cnt), 32'd255);
`endif
    en = 1'b0; bus.rx_valid = 1'b1;
    @(negedge clk);
    en = 1'b1; bus.rx_valid = 1'b0;
    check_val("fl_count", 32'(count), 32'd0);
    check_val("fl_full", 32'(full), 32'd0);
    check_val("fl_valid", 32'(bus.dout_valid), 32'd0);
    check_val("fl_ovf_kept", 32'(overflow), 32'd1);
`ifdef UART_RX_FIFO_DROPCNT_EN
    check_val("fl_dropcnt_kept", 32'(drop_cnt), 32'd255);
`endif
    @(negedge clk);
    check_val("fl_idle_count", 32'(count), 32'd0);
    ovf_clr = 1'b1;
    @(negedge clk);
    ovf_clr = 1'b0;
    check_val("fl_ovf_clr", 32'(overflow), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end
endmodule
